// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency MULT/DIV sequencing with HI/LO
// registers, MTHI/MTLO writes and F/D stall generation.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_MD_I,
    input  logic [2:0]  MDOp_MD_I,
    input  logic [31:0] A_MD_I,
    input  logic [31:0] B_MD_I,
    input  logic        MDUse_MD_I,
    output logic        Busy_MD_O,
    output logic [31:0] HI_MD_O,
    output logic [31:0] LO_MD_O,
    output logic        Stall_MD_O
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        op_r;
    logic [31:0]       a_r, b_r;
    logic [31:0]       hi_r, lo_r;
    logic              accept, done;
    logic [63:0]       mul_res, div_res;

    // Low 64 bits of the product of the extended operands equal the exact 32x32 product.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ax, bx;
        ax = {(sgn ? {32{a[31]}} : 32'h0), a};
        bx = {(sgn ? {32{b[31]}} : 32'h0), b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; signed case divides magnitudes so MIN/-1 wraps cleanly.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        a_neg, b_neg;
        logic [31:0] a_mag, b_mag, q, r;
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        q = (b_mag == 32'h0) ? 32'h0 : a_mag / b_mag;
        r = (b_mag == 32'h0) ? 32'h0 : a_mag % b_mag;
        if (a_neg ^ b_neg) q = -q;
        if (a_neg) r = -r;
        return {r, q};
    endfunction

    assign accept  = (state == IDLE) & Start_MD_I & ~MDOp_MD_I[2];
    assign done    = (state == RUN) & (cnt == CNT_W'(1));
    assign mul_res = mul64(a_r, b_r, ~op_r[0]);
    assign div_res = div64(a_r, b_r, ~op_r[0]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    cnt_nxt   = MDOp_MD_I[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_r <= MDOp_MD_I[1:0];
            a_r  <= A_MD_I;
            b_r  <= B_MD_I;
        end
    end

    // Divide by zero completes normally but leaves HI/LO untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (done) begin
            if (!op_r[1]) begin
                hi_r <= mul_res[63:32];
                lo_r <= mul_res[31:0];
            end else if (b_r != 32'h0) begin
                hi_r <= div_res[63:32];
                lo_r <= div_res[31:0];
            end
        end else if ((state == IDLE) && Start_MD_I) begin
            if (MDOp_MD_I == 3'd4) hi_r <= A_MD_I;
            if (MDOp_MD_I == 3'd5) lo_r <= A_MD_I;
        end
    end

    assign Busy_MD_O  = (state == RUN);
    assign HI_MD_O    = hi_r;
    assign LO_MD_O    = lo_r;
    assign Stall_MD_O = MDUse_MD_I & (Busy_MD_O | (Start_MD_I & ~MDOp_MD_I[2]));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl: latency, arithmetic results, MTHI/MTLO,
// stall generation and reset behaviour.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        mduse;
    logic        busy;
    logic [31:0] hi, lo;
    logic        stall;
    int          tests = 0;
    int          fails = 0;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start_MD_I (start),
        .MDOp_MD_I  (op),
        .A_MD_I     (a),
        .B_MD_I     (b),
        .MDUse_MD_I (mduse),
        .Busy_MD_O  (busy),
        .HI_MD_O    (hi),
        .LO_MD_O    (lo),
        .Stall_MD_O (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0; op = 3'd7; a = '0; b = '0;
    endtask

    // Counts busy cycles after the start edge, bounded so a stuck Busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0; mduse = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_mult();
        int n;
        issue(3'd0, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        tests++; if (n != 5) begin fails++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        tests++; if (lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        tests++; if (n != 5) begin fails++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
        tests++; if (hi !== 32'h00000001) begin fails++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
        tests++; if (lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    endtask

    task automatic test_div();
        int n;
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        tests++; if (n != 10) begin fails++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        // 7 / -2: quotient -3, remainder +1 (sign of dividend)
        issue(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_idle(n);
        tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_negdiv_lo got=%h exp=fffffffd", lo); end
        tests++; if (hi !== 32'h00000001) begin fails++; $display("FAIL div_negdiv_hi got=%h exp=00000001", hi); end
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
        issue(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        tests++; if (n != 10) begin fails++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
        tests++; if (lo !== 32'd3) begin fails++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
        tests++; if (hi !== 32'd1) begin fails++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
    endtask

    task automatic test_div_zero();
        int n;
        issue(3'd4, 32'hAAAA0000, 32'h0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'hAAAA0000) begin fails++; $display("FAIL mthi_hi got=%h exp=aaaa0000", hi); end
        issue(3'd3, 32'd5, 32'd0);
        wait_idle(n);
        tests++; if (n != 10) begin fails++; $display("FAIL divz_busy_cycles got=%0d exp=10", n); end
        tests++; if (hi !== 32'hAAAA0000) begin fails++; $display("FAIL divz_hi got=%h exp=aaaa0000", hi); end
        tests++; if (lo !== 32'd3) begin fails++; $display("FAIL divz_lo got=%h exp=00000003", lo); end
    endtask

    task automatic test_run_ignored();
        int n;
        mduse = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_idle_start got=%b exp=1", stall); end
        tick();
        start = 1'b0; op = 3'd7;
        tick();
        start = 1'b1; op = 3'd5; a = 32'h00001234; b = 32'd0;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_run got=%b exp=1", stall); end
        tick();
        start = 1'b0; op = 3'd7; a = '0;
        tests++; if (lo !== 32'd3) begin fails++; $display("FAIL run_mtlo_ignored got=%h exp=00000003", lo); end
        mduse = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_nouse got=%b exp=0", stall); end
        wait_idle(n);
        tests++; if (n != 3) begin fails++; $display("FAIL run_busy_left got=%0d exp=3", n); end
        tests++; if (lo !== 32'd12) begin fails++; $display("FAIL run_lo got=%h exp=0000000c", lo); end
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL run_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_mtlo_noop();
        mduse = 1'b1; start = 1'b1; op = 3'd5; a = 32'h00001234;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mtlo_stall got=%b exp=0", stall); end
        tick();
        start = 1'b0; op = 3'd7; a = '0; mduse = 1'b0;
        tests++; if (lo !== 32'h00001234) begin fails++; $display("FAIL mtlo_lo got=%h exp=00001234", lo); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
        issue(3'd6, 32'h55555555, 32'h1);
        issue(3'd7, 32'h66666666, 32'h1);
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL noop_busy got=%b exp=0", busy); end
        tests++; if (lo !== 32'h00001234) begin fails++; $display("FAIL noop_lo got=%h exp=00001234", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL noop_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_reset_mid();
        issue(3'd2, 32'd100, 32'd7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_hi got=%h exp=00000000", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_lo got=%h exp=00000000", lo); end
        for (int i = 0; i < 12; i++) tick();
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_late_lo got=%h exp=00000000", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_late_hi got=%h exp=00000000", hi); end
        reset = 1'b1;
        issue(3'd4, 32'hDEADBEEF, 32'h0);
        reset = 1'b0;
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL rst_start_hi got=%h exp=00000000", hi); end
        issue(3'd0, 32'd2, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_start_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_run_ignored();
        test_mtlo_noop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
